// File: rtl/master_round_ctrl.sv
// master_round_ctrl
//   Sequences one round of the chase game on the master side: countdown (TIM),
//   task (TASK), caught (CAUGHT), then a win (STOP) or a loss (FAILED). It runs
//   its own tick-driven round timer and keeps win/lose statistics with win-streak
//   tracking.
//
//   state | meaning
//   IDLE   | waiting for start after reset
//   TIM    | counting down to the task start
//   TASK   | task in progress
//   CAUGHT | master caught, task paused
//   STOP   | round won, waiting for start
//   FAILED | round lost, waiting for start
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   start              begins a round from IDLE/STOP/FAILED (level)
//   tick               timer enable, one cycle wide
//   set_time, ddl_time task start point and round deadline, in ticks
//   selfcaught         masks the deadline check while in TIM
//   caught, stop       game flags from the front end
//   clr_stats          synchronous clear of all statistics
//   state_out          registered state encoding
//   elapsed            round timer
//   win_counter, lose_counter, streak, best_streak  statistics
//   result_valid       one-cycle pulse when a round ends
//   result_win         outcome of the last round (1 = win)
module master_round_ctrl #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TIME_W   = 16,
  parameter int unsigned SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              tick,
  input  logic [TIME_W-1:0] set_time,
  input  logic [TIME_W-1:0] ddl_time,
  input  logic              selfcaught,
  input  logic              caught,
  input  logic              stop,
  input  logic              clr_stats,
  output logic [2:0]        state_out,
  output logic [TIME_W-1:0] elapsed,
  output logic [CNT_W-1:0]  win_counter,
  output logic [CNT_W-1:0]  lose_counter,
  output logic [CNT_W-1:0]  streak,
  output logic [CNT_W-1:0]  best_streak,
  output logic              result_valid,
  output logic              result_win
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TIM    = 3'd1,
    S_TASK   = 3'd2,
    S_CAUGHT = 3'd3,
    S_STOP   = 3'd4,
    S_FAILED = 3'd5
  } state_t;

  localparam logic [TIME_W-1:0] TIME_MAX = {TIME_W{1'b1}};
  localparam logic [TIME_W-1:0] TIME_ONE = {{(TIME_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [TIME_W-1:0]   elapsed_q, elapsed_d;
  logic [CNT_W-1:0]    win_q, win_d, lose_q, lose_d;
  logic [CNT_W-1:0]    streak_q, streak_d, best_q, best_d;
  logic                rv_q, rv_d, rw_q, rw_d;
  logic                start_round, win_ev, loss_ev, running;

  assign running = (state_q == S_TIM) || (state_q == S_TASK) || (state_q == S_CAUGHT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      elapsed_q <= '0;
      win_q     <= '0;
      lose_q    <= '0;
      streak_q  <= '0;
      best_q    <= '0;
      rv_q      <= 1'b0;
      rw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
      streak_q  <= streak_d;
      best_q    <= best_d;
      rv_q      <= rv_d;
      rw_q      <= rw_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_round = 1'b0;
    win_ev      = 1'b0;
    loss_ev     = 1'b0;
    case (state_q)
      S_IDLE, S_STOP, S_FAILED: begin
        if (start) begin
          state_d     = S_TIM;
          start_round = 1'b1;
        end
      end
      S_TIM: begin
        // The task start wins over the deadline, even if set_time >= ddl_time.
        if (elapsed_q == set_time) begin
          state_d = S_TASK;
        end else if (!selfcaught && (elapsed_q >= ddl_time)) begin
          state_d = S_FAILED;
          loss_ev = 1'b1;
        end
      end
      S_TASK: begin
        if (caught) begin
          state_d = S_CAUGHT;
        end else if (stop) begin
          state_d = S_STOP;
          win_ev  = 1'b1;
        end else if (elapsed_q >= ddl_time) begin
          state_d = S_FAILED;
          loss_ev = 1'b1;
        end
      end
      S_CAUGHT: begin
        if (!caught && stop) begin
          state_d = S_STOP;
          win_ev  = 1'b1;
        end else if (!caught) begin
          state_d = S_TASK;
        end else if (elapsed_q >= ddl_time) begin
          state_d = S_FAILED;
          loss_ev = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    elapsed_d = elapsed_q;
    if (start_round) begin
      elapsed_d = '0;
    end else if (tick && running && (elapsed_q != TIME_MAX)) begin
      elapsed_d = elapsed_q + TIME_ONE;
    end
  end

  // A same-edge clear discards the result of the round that just ended.
  always_comb begin
    win_d    = win_q;
    lose_d   = lose_q;
    streak_d = streak_q;
    best_d   = best_q;
    if (clr_stats) begin
      win_d    = '0;
      lose_d   = '0;
      streak_d = '0;
      best_d   = '0;
    end else if (win_ev) begin
      if (win_q != CNT_MAX) win_d = win_q + CNT_ONE;
      else                  win_d = (SATURATE != 0) ? CNT_MAX : '0;
      if (streak_q != CNT_MAX) streak_d = streak_q + CNT_ONE;
      if (streak_d > best_q) best_d = streak_d;
    end else if (loss_ev) begin
      if (lose_q != CNT_MAX) lose_d = lose_q + CNT_ONE;
      else                   lose_d = (SATURATE != 0) ? CNT_MAX : '0;
      streak_d = '0;
    end
  end

  always_comb begin
    rv_d = win_ev || loss_ev;
    rw_d = rv_d ? win_ev : rw_q;
  end

  assign state_out    = state_q;
  assign elapsed      = elapsed_q;
  assign win_counter  = win_q;
  assign lose_counter = lose_q;
  assign streak       = streak_q;
  assign best_streak  = best_q;
  assign result_valid = rv_q;
  assign result_win   = rw_q;

endmodule

// File: tb/tb_master_round_ctrl.sv
module tb_master_round_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, tick = 1'b0, selfcaught = 1'b0, caught = 1'b0, stop = 1'b0, clr_stats = 1'b0;
  logic [15:0] set_time = '0, ddl_time = '0;

  // main instance (CNT_W=8, saturating) and two narrow instances for overflow
  logic [2:0]  so_m, so_s, so_w;
  logic [15:0] el_m, el_s, el_w;
  logic [7:0]  win_m, lose_m, str_m, best_m;
  logic [1:0]  win_s, lose_s, str_s, best_s;
  logic [1:0]  win_w, lose_w, str_w, best_w;
  logic        rv_m, rw_m, rv_s, rw_s, rv_w, rw_w;

  master_round_ctrl #(.CNT_W(8), .TIME_W(16), .SATURATE(1)) u_main (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .set_time(set_time), .ddl_time(ddl_time),
    .selfcaught(selfcaught), .caught(caught), .stop(stop), .clr_stats(clr_stats),
    .state_out(so_m), .elapsed(el_m), .win_counter(win_m), .lose_counter(lose_m),
    .streak(str_m), .best_streak(best_m), .result_valid(rv_m), .result_win(rw_m));

  master_round_ctrl #(.CNT_W(2), .TIME_W(16), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .set_time(set_time), .ddl_time(ddl_time),
    .selfcaught(selfcaught), .caught(caught), .stop(stop), .clr_stats(clr_stats),
    .state_out(so_s), .elapsed(el_s), .win_counter(win_s), .lose_counter(lose_s),
    .streak(str_s), .best_streak(best_s), .result_valid(rv_s), .result_win(rw_s));

  master_round_ctrl #(.CNT_W(2), .TIME_W(16), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .set_time(set_time), .ddl_time(ddl_time),
    .selfcaught(selfcaught), .caught(caught), .stop(stop), .clr_stats(clr_stats),
    .state_out(so_w), .elapsed(el_w), .win_counter(win_w), .lose_counter(lose_w),
    .streak(str_w), .best_streak(best_w), .result_valid(rv_w), .result_win(rw_w));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model (round phases as plain integers) --------
  localparam int P_IDLE = 0, P_TIM = 1, P_TASK = 2, P_CAUGHT = 3, P_STOP = 4, P_FAILED = 5;
  int m_state, m_el, m_rv, m_rw;
  int m_win[3], m_lose[3], m_str[3], m_best[3];
  int cmax[3] = '{255, 3, 3};
  int csat[3] = '{1, 1, 0};

  task automatic model_reset();
    m_state = P_IDLE; m_el = 0; m_rv = 0; m_rw = 0;
    for (int k = 0; k < 3; k++) begin
      m_win[k] = 0; m_lose[k] = 0; m_str[k] = 0; m_best[k] = 0;
    end
  endtask

  task automatic model_step();
    int  nxt;
    bit  won, lost, fresh;
    bit  late;
    nxt = m_state; won = 0; lost = 0; fresh = 0;
    late = (m_el >= int'(ddl_time));
    if (m_state == P_IDLE || m_state == P_STOP || m_state == P_FAILED) begin
      if (start) begin nxt = P_TIM; fresh = 1; end
    end else if (m_state == P_TIM) begin
      if (m_el == int'(set_time)) nxt = P_TASK;
      else if (!selfcaught && late) begin nxt = P_FAILED; lost = 1; end
    end else if (m_state == P_TASK) begin
      if (caught) nxt = P_CAUGHT;
      else if (stop) begin nxt = P_STOP; won = 1; end
      else if (late) begin nxt = P_FAILED; lost = 1; end
    end else if (m_state == P_CAUGHT) begin
      if (!caught) begin
        nxt = stop ? P_STOP : P_TASK;
        won = stop;
      end else if (late) begin nxt = P_FAILED; lost = 1; end
    end else begin
      nxt = P_IDLE;
    end

    if (fresh) m_el = 0;
    else if (tick && m_state >= P_TIM && m_state <= P_CAUGHT && m_el < 65535) m_el = m_el + 1;

    for (int k = 0; k < 3; k++) begin
      if (clr_stats) begin
        m_win[k] = 0; m_lose[k] = 0; m_str[k] = 0; m_best[k] = 0;
      end else if (won) begin
        m_win[k] = csat[k] ? ((m_win[k] + 1 > cmax[k]) ? cmax[k] : m_win[k] + 1)
                           : (m_win[k] + 1) % (cmax[k] + 1);
        m_str[k] = (m_str[k] + 1 > cmax[k]) ? cmax[k] : m_str[k] + 1;
        if (m_str[k] > m_best[k]) m_best[k] = m_str[k];
      end else if (lost) begin
        m_lose[k] = csat[k] ? ((m_lose[k] + 1 > cmax[k]) ? cmax[k] : m_lose[k] + 1)
                            : (m_lose[k] + 1) % (cmax[k] + 1);
        m_str[k] = 0;
      end
    end
    m_rv = (won || lost) ? 1 : 0;
    if (won || lost) m_rw = won ? 1 : 0;
    m_state = nxt;
  endtask

  task automatic chk_model();
    chk("state", so_m, m_state);
    chk("elapsed", el_m, m_el);
    chk("result_valid", rv_m, m_rv);
    chk("result_win", rw_m, m_rw);
    chk("win", win_m, m_win[0]);
    chk("lose", lose_m, m_lose[0]);
    chk("streak", str_m, m_str[0]);
    chk("best", best_m, m_best[0]);
    chk("state_sat", so_s, m_state);
    chk("rv_sat", rv_s, m_rv);
    chk("win_sat", win_s, m_win[1]);
    chk("lose_sat", lose_s, m_lose[1]);
    chk("streak_sat", str_s, m_str[1]);
    chk("best_sat", best_s, m_best[1]);
    chk("state_wrap", so_w, m_state);
    chk("win_wrap", win_w, m_win[2]);
    chk("lose_wrap", lose_w, m_lose[2]);
    chk("streak_wrap", str_w, m_str[2]);
    chk("best_wrap", best_w, m_best[2]);
    chk("rw_wrap", rw_w, m_rw);
  endtask

  // inputs are set #1 after a rising edge; the next edge samples them
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk_model();
  endtask

  task automatic set_in(input bit st, input bit tk, input int s, input int d,
                        input bit sc, input bit cg, input bit sp, input bit cl);
    start = st; tick = tk; set_time = 16'(s); ddl_time = 16'(d);
    selfcaught = sc; caught = cg; stop = sp; clr_stats = cl;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_state", so_m, 0);
    chk("rst_elapsed", el_m, 0);
    chk("rst_win", win_m, 0);
    chk("rst_lose", lose_m, 0);
    chk("rst_streak", str_m, 0);
    chk("rst_best", best_m, 0);
    chk("rst_rv", rv_m, 0);
    chk("rst_rw", rw_m, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic do_win();
    set_in(1, 1, 0, 100, 0, 0, 0, 0); cycle();
    start = 0; cycle();
    stop = 1; cycle();
    stop = 0; cycle();
  endtask

  task automatic do_loss();
    set_in(1, 1, 0, 0, 0, 0, 0, 0); cycle();
    start = 0; cycle();
    cycle();
    cycle();
  endtask

  // ---------------- vector table: basic win, then TIM deadline -------------
  typedef struct {
    bit          start;
    bit          stop;
    logic [15:0] set_t;
    logic [15:0] ddl_t;
    int          e_state, e_el, e_rv, e_rw, e_win, e_lose, e_str, e_best;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(bit st, int s, int d, bit sp, int es, int ee, int erv, int erw,
                              int ew, int el, int estr, int eb);
    vec_t v;
    v.start = st; v.stop = sp; v.set_t = 16'(s); v.ddl_t = 16'(d);
    v.e_state = es; v.e_el = ee; v.e_rv = erv; v.e_rw = erw;
    v.e_win = ew; v.e_lose = el; v.e_str = estr; v.e_best = eb;
    return v;
  endfunction

  initial begin
    tbl[0] = mk(1, 3, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) tbl[i] = mk(0, 3, 10, 0, 1, i, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(0, 3, 10, 0, 2, 4, 0, 0, 0, 0, 0, 0);
    tbl[5] = mk(0, 3, 10, 1, 4, 5, 1, 1, 1, 0, 1, 1);
    tbl[6] = mk(0, 3, 10, 0, 4, 5, 0, 1, 1, 0, 1, 1);
    tbl[7] = mk(1, 20, 5, 0, 1, 0, 0, 1, 1, 0, 1, 1);
    for (int i = 8; i <= 12; i++) tbl[i] = mk(0, 20, 5, 0, 1, i - 7, 0, 1, 1, 0, 1, 1);
    tbl[13] = mk(0, 20, 5, 0, 5, 6, 1, 0, 1, 1, 0, 1);
    tbl[14] = mk(0, 20, 5, 0, 5, 6, 0, 0, 1, 1, 0, 1);

    #2;
    do_reset();

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].start, 1, int'(tbl[i].set_t), int'(tbl[i].ddl_t), 0, 0, tbl[i].stop, 0);
      cycle();
      chk($sformatf("tbl%0d_state", i), so_m, tbl[i].e_state);
      chk($sformatf("tbl%0d_elapsed", i), el_m, tbl[i].e_el);
      chk($sformatf("tbl%0d_rv", i), rv_m, tbl[i].e_rv);
      chk($sformatf("tbl%0d_rw", i), rw_m, tbl[i].e_rw);
      chk($sformatf("tbl%0d_win", i), win_m, tbl[i].e_win);
      chk($sformatf("tbl%0d_lose", i), lose_m, tbl[i].e_lose);
      chk($sformatf("tbl%0d_streak", i), str_m, tbl[i].e_str);
      chk($sformatf("tbl%0d_best", i), best_m, tbl[i].e_best);
    end

    // selfcaught masks the TIM deadline: TASK at elapsed 20
    do_reset();
    set_in(1, 1, 20, 5, 1, 0, 0, 0); cycle();
    start = 0;
    repeat (20) cycle();
    chk("selfc_still_tim", so_m, 1);
    chk("selfc_el20", el_m, 20);
    cycle();
    chk("selfc_task", so_m, 2);

    // caught until the deadline, then a caught-release win on a fresh round
    do_reset();
    set_in(1, 1, 2, 8, 0, 0, 0, 0); cycle();
    start = 0;
    repeat (3) cycle();
    chk("cd_task", so_m, 2);
    caught = 1; cycle();
    chk("cd_caught", so_m, 3);
    repeat (4) cycle();
    chk("cd_caught_el8", so_m, 3);
    cycle();
    chk("cd_failed", so_m, 5);
    chk("cd_rv", rv_m, 1);
    chk("cd_rw", rw_m, 0);
    chk("cd_lose", lose_m, 1);
    caught = 0; start = 1; cycle();
    start = 0;
    repeat (3) cycle();
    caught = 1; cycle();
    chk("cw_caught", so_m, 3);
    caught = 0; stop = 1; cycle();
    chk("cw_stop", so_m, 4);
    chk("cw_rw", rw_m, 1);
    chk("cw_win", win_m, 1);
    stop = 0; cycle();

    // streaks W,W,W,L,W
    do_reset();
    do_win(); do_win(); do_win(); do_loss(); do_win();
    chk("str_streak", str_m, 1);
    chk("str_best", best_m, 3);
    chk("str_win", win_m, 4);
    chk("str_lose", lose_m, 1);

    // overflow on the narrow instances
    do_reset();
    repeat (5) do_win();
    chk("ovf_win_sat", win_s, 3);
    chk("ovf_win_wrap", win_w, 1);
    chk("ovf_str_sat", str_s, 3);
    chk("ovf_str_wrap", str_w, 3);
    chk("ovf_win_main", win_m, 5);

    // clear on the winning edge
    set_in(1, 1, 0, 100, 0, 0, 0, 0); cycle();
    start = 0; cycle();
    stop = 1; clr_stats = 1; cycle();
    chk("clr_state", so_m, 4);
    chk("clr_rv", rv_m, 1);
    chk("clr_rw", rw_m, 1);
    chk("clr_win", win_m, 0);
    chk("clr_lose", lose_m, 0);
    chk("clr_streak", str_m, 0);
    chk("clr_best", best_m, 0);
    stop = 0; clr_stats = 0; cycle();

    // reset in the middle of TASK aborts without a pulse
    do_win();
    set_in(1, 1, 0, 100, 0, 0, 0, 0); cycle();
    start = 0; cycle();
    chk("mid_task", so_m, 2);
    stop = 1;
    do_reset();
    set_in(0, 1, 0, 100, 0, 0, 0, 0); cycle();
    chk("mid_no_pulse", rv_m, 0);
    chk("mid_idle", so_m, 0);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 40 == 0) begin
        set_time = 16'($urandom_range(0, 12));
        ddl_time = 16'($urandom_range(0, 16));
      end
      start      = ($urandom_range(0, 3) == 0);
      tick       = ($urandom_range(0, 3) != 0);
      selfcaught = ($urandom_range(0, 4) == 0);
      caught     = ($urandom_range(0, 4) == 0);
      stop       = ($urandom_range(0, 4) == 0);
      clr_stats  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
